// File: rtl/fsm_event_logger_pkg.sv
// Shared constants and width helpers for the sequence-detector event logger.
// Entry width depends on the LOGGER_TIMESTAMP_EN build option.
package fsm_logger_pkg;

    localparam int STATE_W = 3;

    // Without the timestamp feature the ts width contributes nothing to an entry.
    function automatic int ent_width(input int ts_w);
`ifdef LOGGER_TIMESTAMP_EN
        return STATE_W + ts_w;
`else
        return STATE_W + (ts_w * 0);
`endif
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fsm_event_logger_if.sv
// Host read port of the event logger: FWFT head entry, status flags and pop strobe.
interface fsm_event_logger_if
    import fsm_logger_pkg::*;
#(
    parameter int ENT_W = STATE_W
) ();

    logic             rd_en;
    logic [ENT_W-1:0] dout;
    logic             empty;
    logic             full;

    modport master (output rd_en, input dout, empty, full);
    modport slave  (input rd_en, output dout, empty, full);

endinterface

// File: rtl/fsm_event_logger_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy counter and a
// combinational indication of a push that had to be dropped.
module logger_fifo
    import fsm_logger_pkg::*;
#(
    parameter int WIDTH = STATE_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             dropped
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in, even when full.
    assign push_ok = push && (!full || pop_ok);
    assign dropped = push && !push_ok;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fsm_event_logger.sv
// Event logger for the sequence detector: counts rising edges of F and queues {S[, ts]}.
// Build option LOGGER_TIMESTAMP_EN appends a free-running cycle timestamp to each entry.
module fsm_event_logger
    import fsm_logger_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    parameter int TS_W  = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               F,
    input  logic [STATE_W-1:0] S,
    output logic               overflow,
    output logic [CNT_W-1:0]   evt_count,
    fsm_event_logger_if.slave  host
);

    localparam int ENT_W = ent_width(TS_W);

    logic             f_q;
    logic             evt;
    logic             dropped;
    logic [ENT_W-1:0] entry;

    // f_q resets low so a flag already high after reset counts as an edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            f_q <= 1'b0;
        end else begin
            f_q <= F;
        end
    end

    assign evt = F && !f_q;

`ifdef LOGGER_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    assign entry = {S, ts};
`else
    assign entry = S;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            evt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (evt && (evt_count != '1)) begin
                evt_count <= evt_count + CNT_W'(1);
            end
            if (dropped) begin
                overflow <= 1'b1;
            end
        end
    end

    logger_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESET),
        .push    (evt),
        .wdata   (entry),
        .pop     (host.rd_en),
        .rdata   (host.dout),
        .empty   (host.empty),
        .full    (host.full),
        .dropped (dropped)
    );

endmodule

// File: tb/tb_fsm_event_logger.sv
// Self-checking bench for fsm_event_logger: directed vector table, async reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_fsm_event_logger;
    import fsm_logger_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int SAT_W = 3;
    localparam int TS_W  = 8;
    localparam int ENT_W = ent_width(TS_W);
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int SAT_MAX = (1 << SAT_W) - 1;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             F = 1'b0;
    logic [2:0]       S = 3'd0;
    logic             rd = 1'b0;
    logic             overflow;
    logic             overflow_sat;
    logic [CNT_W-1:0] evt_count;
    logic [SAT_W-1:0] evt_count_sat;

    fsm_event_logger_if #(.ENT_W(ENT_W)) host_if ();
    fsm_event_logger_if #(.ENT_W(ENT_W)) sat_if ();

    assign host_if.rd_en = rd;
    assign sat_if.rd_en  = rd;

    fsm_event_logger #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .F         (F),
        .S         (S),
        .overflow  (overflow),
        .evt_count (evt_count),
        .host      (host_if.slave)
    );

    // Same stimulus, narrow counter to exercise saturation.
    fsm_event_logger #(.DEPTH(DEPTH), .CNT_W(SAT_W), .TS_W(TS_W)) dut_sat (
        .CLK       (CLK),
        .RESET     (RESET),
        .F         (F),
        .S         (S),
        .overflow  (overflow_sat),
        .evt_count (evt_count_sat),
        .host      (sat_if.slave)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int entryOf(input logic [2:0] s, input int ts);
`ifdef LOGGER_TIMESTAMP_EN
        return (int'(s) << TS_W) | (ts % (1 << TS_W));
`else
        return int'(s) + (ts * 0);
`endif
    endfunction

    function automatic int satTo(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    // Reference model: the FIFO is a queue, counts are plain integers.
    int m_q[$];
    int m_cnt  = 0;
    bit m_ovf  = 1'b0;
    int m_ts   = 0;
    bit m_prev = 1'b0;
    bit m_evt;
    bit m_pop;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_q.delete();
            m_cnt  = 0;
            m_ovf  = 1'b0;
            m_ts   = 0;
            m_prev = 1'b0;
        end else begin
            m_evt = F && !m_prev;
            m_pop = rd && (m_q.size() != 0);
            if (m_pop) void'(m_q.pop_front());
            if (m_evt) begin
                m_cnt++;
                if (m_q.size() < DEPTH) m_q.push_back(entryOf(S, m_ts));
                else m_ovf = 1'b1;
            end
            m_prev = F;
            m_ts++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit f, input logic [2:0] s, input bit r);
        F  = f;
        S  = s;
        rd = r;
        @(negedge CLK);
    endtask

    task automatic doReset(input string tag);
        #2;
        RESET = 1'b0;
        F = 1'b0;
        S = 3'd0;
        rd = 1'b0;
        #1;
        checkOutput({tag, " rst empty"}, 32'(host_if.empty), 32'd1);
        checkOutput({tag, " rst full"}, 32'(host_if.full), 32'd0);
        checkOutput({tag, " rst overflow"}, 32'(overflow), 32'd0);
        checkOutput({tag, " rst evt_count"}, 32'(evt_count), 32'd0);
        checkOutput({tag, " rst evt_count_sat"}, 32'(evt_count_sat), 32'd0);
        checkOutput({tag, " rst dout"}, 32'(host_if.dout), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " empty"}, 32'(host_if.empty), 32'(m_q.size() == 0));
        checkOutput({tag, " full"}, 32'(host_if.full), 32'(m_q.size() == DEPTH));
        checkOutput({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
        checkOutput({tag, " evt_count"}, 32'(evt_count), 32'(satTo(m_cnt, CNT_MAX)));
        checkOutput({tag, " evt_count_sat"}, 32'(evt_count_sat), 32'(satTo(m_cnt, SAT_MAX)));
        checkOutput({tag, " overflow_sat"}, 32'(overflow_sat), 32'(m_ovf));
        checkOutput({tag, " empty_sat"}, 32'(sat_if.empty), 32'(m_q.size() == 0));
        if (m_q.size() != 0) begin
            checkOutput({tag, " dout"}, 32'(host_if.dout), 32'(m_q[0]));
            checkOutput({tag, " dout_sat"}, 32'(sat_if.dout), 32'(m_q[0]));
        end
    endtask

    typedef struct {
        bit       f;
        bit [2:0] s;
        bit       rd;
        bit       e_empty;
        bit       e_full;
        bit       e_ovf;
        int       e_cnt;
        bit       chk;
        bit [2:0] e_s;
        int       e_ts;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input bit f, input bit [2:0] s, input bit rd_i,
                          input bit e_empty, input bit e_full, input bit e_ovf, input int e_cnt,
                          input bit chk, input bit [2:0] e_s, input int e_ts);
        vec_t v;
        v = '{f, s, rd_i, e_empty, e_full, e_ovf, e_cnt, chk, e_s, e_ts};
        vecs.push_back(v);
    endtask

    initial begin
        // Row k is sampled at the k-th clock edge after reset release, so ts = k.
        for (int i = 0; i < 5; i++) addVec(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        addVec(1, 5, 0, 0, 0, 0, 1, 1, 5, 5);
        for (int i = 0; i < 3; i++) addVec(1, 5, 0, 0, 0, 0, 1, 1, 5, 5);
        addVec(0, 2, 0, 0, 0, 0, 1, 1, 5, 5);
        addVec(1, 1, 0, 0, 0, 0, 2, 1, 5, 5);
        addVec(0, 0, 0, 0, 0, 0, 2, 1, 5, 5);
        addVec(1, 2, 0, 0, 0, 0, 3, 1, 5, 5);
        addVec(0, 0, 0, 0, 0, 0, 3, 1, 5, 5);
        addVec(1, 3, 0, 0, 1, 0, 4, 1, 5, 5);
        addVec(0, 0, 0, 0, 1, 0, 4, 1, 5, 5);
        addVec(1, 4, 1, 0, 1, 0, 5, 1, 1, 10);
        addVec(0, 0, 0, 0, 1, 0, 5, 1, 1, 10);
        addVec(1, 6, 0, 0, 1, 1, 6, 1, 1, 10);
        addVec(0, 0, 1, 0, 0, 1, 6, 1, 2, 12);
        addVec(0, 0, 1, 0, 0, 1, 6, 1, 3, 14);
        addVec(0, 0, 1, 0, 0, 1, 6, 1, 4, 16);
        addVec(0, 0, 1, 1, 0, 1, 6, 0, 0, 0);
        addVec(0, 0, 1, 1, 0, 1, 6, 0, 0, 0);
        addVec(1, 3, 1, 0, 0, 1, 7, 1, 3, 24);
        addVec(0, 0, 1, 1, 0, 1, 7, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 1, 8, 1, 0, 26);
        addVec(0, 0, 1, 1, 0, 1, 8, 0, 0, 0);
        addVec(1, 1, 0, 0, 0, 1, 9, 1, 1, 28);
        addVec(0, 0, 0, 0, 0, 1, 9, 1, 1, 28);
        addVec(1, 2, 0, 0, 0, 1, 10, 1, 1, 28);

        doReset("init");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].f, vecs[i].s, vecs[i].rd);
            checkOutput($sformatf("vec%0d empty", i), 32'(host_if.empty), 32'(vecs[i].e_empty));
            checkOutput($sformatf("vec%0d full", i), 32'(host_if.full), 32'(vecs[i].e_full));
            checkOutput($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
            checkOutput($sformatf("vec%0d evt_count", i), 32'(evt_count), 32'(vecs[i].e_cnt));
            checkOutput($sformatf("vec%0d evt_count_sat", i), 32'(evt_count_sat),
                        32'(satTo(vecs[i].e_cnt, SAT_MAX)));
            if (vecs[i].chk) begin
                checkOutput($sformatf("vec%0d dout", i), 32'(host_if.dout),
                            32'(entryOf(vecs[i].e_s, vecs[i].e_ts)));
            end
        end

        // Two entries queued and overflow set: asynchronous reset flushes everything.
        doReset("midop");
        applyStimulus(1, 5, 0);
        checkOutput("post-reset empty", 32'(host_if.empty), 32'd0);
        checkOutput("post-reset evt_count", 32'(evt_count), 32'd1);
        checkOutput("post-reset dout ts0", 32'(host_if.dout), 32'(entryOf(3'd5, 0)));
        applyStimulus(0, 0, 1);
        checkOutput("post-reset drained", 32'(host_if.empty), 32'd1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset($sformatf("rand%0d", i));
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                              $urandom_range(0, 2) == 0);
                checkModel($sformatf("rand%0d", i));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
